// File: rtl/ncap_intr_ctrl.sv
// NCAP interrupt delivery: monitor event -> MSI request -> driver ack -> holdoff,
// with a one-deep coalescing backlog slot. Optional ack timeout/retry via NCAP_INTR_TIMEOUT_EN.
module ncap_intr_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ncap_intr,
    input  logic             ncap_intr_type,
    input  logic [31:0]      holdoff,
    input  logic [31:0]      ack_timeout,
    output logic             msi_req,
    output logic             msi_vector,
    input  logic             msi_grant,
    input  logic             drv_ack,
    output logic             busy,
    output logic             cur_type,
    output logic             pend_valid,
    output logic [CNT_W-1:0] sent_count,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'b0001,
        S_REQ      = 4'b0010,
        S_WAIT_ACK = 4'b0100,
        S_HOLDOFF  = 4'b1000
    } state_t;

    state_t           state_q, state_d;
    logic             cur_type_q, cur_type_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pend_type_q, pend_type_d;
    logic [CNT_W-1:0] sent_count_q, sent_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic [31:0]      hold_cnt_q, hold_cnt_d;
    logic             msi_req_q, msi_req_d;
    logic             msi_vector_q, msi_vector_d;
    logic             busy_q, busy_d;

`ifdef NCAP_INTR_TIMEOUT_EN
    logic [31:0]      wait_cnt_q, wait_cnt_d;
    logic             ack_expired;

    // Fires on the ack_timeout-th cycle spent in WAIT_ACK.
    assign ack_expired = (ack_timeout != 32'd0) && ((wait_cnt_q + 32'd1) == ack_timeout);
`else
    logic             unused_ack_timeout;

    assign unused_ack_timeout = ^ack_timeout;
`endif

    always_comb begin
        state_d      = state_q;
        cur_type_d   = cur_type_q;
        pend_valid_d = pend_valid_q;
        pend_type_d  = pend_type_q;
        sent_count_d = sent_count_q;
        drop_count_d = drop_count_q;
        hold_cnt_d   = hold_cnt_q;
`ifdef NCAP_INTR_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pend_valid_q) begin
                    // Backlog goes first; a simultaneous new event refills the slot without a drop.
                    cur_type_d   = pend_type_q;
                    pend_valid_d = ncap_intr;
                    if (ncap_intr) begin
                        pend_type_d = ncap_intr_type;
                    end
                    state_d      = S_REQ;
                end else if (ncap_intr) begin
                    cur_type_d = ncap_intr_type;
                    state_d    = S_REQ;
                end
            end

            S_REQ: begin
                if (msi_grant) begin
                    sent_count_d = sent_count_q + CNT_W'(1);
                    state_d      = S_WAIT_ACK;
`ifdef NCAP_INTR_TIMEOUT_EN
                    wait_cnt_d   = 32'd0;
`endif
                end
            end

            S_WAIT_ACK: begin
                if (drv_ack) begin
                    if (holdoff == 32'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        hold_cnt_d = holdoff;
                        state_d    = S_HOLDOFF;
                    end
`ifdef NCAP_INTR_TIMEOUT_EN
                end else if (ack_expired) begin
                    state_d = S_REQ;
                end else begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
`endif
                end
            end

            S_HOLDOFF: begin
                hold_cnt_d = hold_cnt_q - 32'd1;
                if (hold_cnt_q <= 32'd1) begin
                    hold_cnt_d = 32'd0;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Events arriving while busy land in the slot; newest type wins on overwrite.
        if ((state_q != S_IDLE) && ncap_intr) begin
            pend_type_d = ncap_intr_type;
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
            end else if (!(&drop_count_q)) begin
                drop_count_d = drop_count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        msi_req_d    = (state_d == S_REQ);
        msi_vector_d = cur_type_d;
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_type_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_type_q  <= 1'b0;
            sent_count_q <= '0;
            drop_count_q <= '0;
            hold_cnt_q   <= 32'd0;
            msi_req_q    <= 1'b0;
            msi_vector_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef NCAP_INTR_TIMEOUT_EN
            wait_cnt_q   <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            cur_type_q   <= cur_type_d;
            pend_valid_q <= pend_valid_d;
            pend_type_q  <= pend_type_d;
            sent_count_q <= sent_count_d;
            drop_count_q <= drop_count_d;
            hold_cnt_q   <= hold_cnt_d;
            msi_req_q    <= msi_req_d;
            msi_vector_q <= msi_vector_d;
            busy_q       <= busy_d;
`ifdef NCAP_INTR_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign msi_req    = msi_req_q;
    assign msi_vector = msi_vector_q;
    assign busy       = busy_q;
    assign cur_type   = cur_type_q;
    assign pend_valid = pend_valid_q;
    assign sent_count = sent_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_ncap_intr_ctrl.sv
// Directed bench for ncap_intr_ctrl: a vector table for the main flow plus
// hand-written sequences for holdoff timing, drop saturation, reset and ack timeout.
module tb_ncap_intr_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ncap_intr;
    logic             ncap_intr_type;
    logic [31:0]      holdoff;
    logic [31:0]      ack_timeout;
    logic             msi_req;
    logic             msi_vector;
    logic             msi_grant;
    logic             drv_ack;
    logic             busy;
    logic             cur_type;
    logic             pend_valid;
    logic [CNT_W-1:0] sent_count;
    logic [CNT_W-1:0] drop_count;

    int n_chk  = 0;
    int n_pass = 0;

    ncap_intr_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ncap_intr      (ncap_intr),
        .ncap_intr_type (ncap_intr_type),
        .holdoff        (holdoff),
        .ack_timeout    (ack_timeout),
        .msi_req        (msi_req),
        .msi_vector     (msi_vector),
        .msi_grant      (msi_grant),
        .drv_ack        (drv_ack),
        .busy           (busy),
        .cur_type       (cur_type),
        .pend_valid     (pend_valid),
        .sent_count     (sent_count),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, intr, typ, grant, ack;
        logic [31:0] hold;
        logic        e_req, e_vec, e_busy, e_cur, e_pend;
        logic [3:0]  e_sent, e_drop;
    } vec_t;

    vec_t tv[25];

    function automatic vec_t mk(input logic r, input logic i, input logic t, input logic g,
                                input logic a, input logic [31:0] h, input logic q,
                                input logic v, input logic b, input logic c, input logic p,
                                input logic [3:0] s, input logic [3:0] d);
        vec_t x;
        x.rst = r; x.intr = i; x.typ = t; x.grant = g; x.ack = a; x.hold = h;
        x.e_req = q; x.e_vec = v; x.e_busy = b; x.e_cur = c; x.e_pend = p;
        x.e_sent = s; x.e_drop = d;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ncap_intr = 0; ncap_intr_type = 0; msi_grant = 0; drv_ack = 0; holdoff = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        logic saw_req;
        rst = 1; ack_timeout = 0;
        clear_inputs();

        //           rst i t g a hold | req vec busy cur pend sent drop
        tv[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0); // stray grant+ack in IDLE
        tv[2]  = mk(0, 1, 1, 0, 0, 0,   1, 1, 1, 1, 0, 0, 0);
        tv[3]  = mk(0, 0, 0, 0, 0, 0,   1, 1, 1, 1, 0, 0, 0);
        tv[4]  = mk(0, 0, 0, 1, 1, 0,   0, 1, 1, 1, 0, 1, 0); // ack with grant ignored
        tv[5]  = mk(0, 0, 0, 1, 0, 0,   0, 1, 1, 1, 0, 1, 0); // stray grant in WAIT_ACK
        tv[6]  = mk(0, 1, 1, 0, 0, 0,   0, 1, 1, 1, 1, 1, 0);
        tv[7]  = mk(0, 1, 0, 0, 0, 0,   0, 1, 1, 1, 1, 1, 1);
        tv[8]  = mk(0, 1, 0, 0, 0, 0,   0, 1, 1, 1, 1, 1, 2);
        tv[9]  = mk(0, 0, 0, 0, 1, 0,   0, 1, 0, 1, 1, 1, 2); // holdoff 0 -> IDLE
        tv[10] = mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 1, 2); // slot (type 0) issues
        tv[11] = mk(0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 2, 2);
        tv[12] = mk(0, 0, 0, 0, 1, 3,   0, 0, 1, 0, 0, 2, 2); // holdoff 3
        tv[13] = mk(0, 1, 1, 0, 0, 3,   0, 0, 1, 0, 1, 2, 2); // event during HOLDOFF
        tv[14] = mk(0, 0, 0, 0, 0, 3,   0, 0, 1, 0, 1, 2, 2);
        tv[15] = mk(0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 1, 2, 2);
        tv[16] = mk(0, 1, 0, 0, 0, 3,   1, 1, 1, 1, 1, 2, 2); // dequeue + refill, no drop
        tv[17] = mk(0, 0, 0, 1, 0, 3,   0, 1, 1, 1, 1, 3, 2);
        tv[18] = mk(0, 0, 0, 0, 1, 0,   0, 1, 0, 1, 1, 3, 2);
        tv[19] = mk(0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 3, 2);
        tv[20] = mk(0, 0, 0, 1, 0, 0,   0, 0, 1, 0, 0, 4, 2);
        tv[21] = mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 4, 2);
        tv[22] = mk(0, 1, 1, 0, 0, 0,   1, 1, 1, 1, 0, 4, 2); // direct issue, slot untouched
        tv[23] = mk(0, 1, 0, 0, 0, 0,   1, 1, 1, 1, 1, 4, 2);
        tv[24] = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0); // reset mid-REQ, slot full

        for (int i = 0; i < 25; i++) begin
            rst = tv[i].rst; ncap_intr = tv[i].intr; ncap_intr_type = tv[i].typ;
            msi_grant = tv[i].grant; drv_ack = tv[i].ack; holdoff = tv[i].hold;
            tick();
            chk($sformatf("row%0d.msi_req", i),    32'(msi_req),    32'(tv[i].e_req));
            chk($sformatf("row%0d.msi_vector", i), 32'(msi_vector), 32'(tv[i].e_vec));
            chk($sformatf("row%0d.busy", i),       32'(busy),       32'(tv[i].e_busy));
            chk($sformatf("row%0d.cur_type", i),   32'(cur_type),   32'(tv[i].e_cur));
            chk($sformatf("row%0d.pend_valid", i), 32'(pend_valid), 32'(tv[i].e_pend));
            chk($sformatf("row%0d.sent_count", i), 32'(sent_count), 32'(tv[i].e_sent));
            chk($sformatf("row%0d.drop_count", i), 32'(drop_count), 32'(tv[i].e_drop));
        end
        rst = 0;
        clear_inputs();

        // Single event: request for three cycles, grant on the third, then holdoff 5.
        do_reset();
        tick();
        ncap_intr = 1; ncap_intr_type = 1;
        tick();
        ncap_intr = 0;
        chk("single.req_n1", 32'(msi_req), 1);
        chk("single.vec", 32'(msi_vector), 1);
        tick();
        chk("single.req_n2", 32'(msi_req), 1);
        tick();
        chk("single.req_n3", 32'(msi_req), 1);
        msi_grant = 1;
        tick();
        msi_grant = 0;
        chk("single.req_after_grant", 32'(msi_req), 0);
        chk("single.sent", 32'(sent_count), 1);
        tick(); tick();
        drv_ack = 1; holdoff = 5;
        for (int k = 1; k <= 6; k++) begin
            tick();
            drv_ack = 0; ncap_intr = 0;
            chk($sformatf("holdoff.busy_a%0d", k), 32'(busy), (k <= 5) ? 32'd1 : 32'd0);
            chk($sformatf("holdoff.req_a%0d", k), 32'(msi_req), 0);
            if (k == 5) begin
                ncap_intr = 1; ncap_intr_type = 0;
            end
        end
        tick();
        chk("holdoff.req_a7", 32'(msi_req), 1);
        chk("holdoff.vec_a7", 32'(msi_vector), 0);
        clear_inputs();

        // Drop counter saturates at 15 with 20 coalesced events.
        do_reset();
        ncap_intr = 1; ncap_intr_type = 1;
        tick();
        for (int i = 1; i <= 21; i++) begin
            ncap_intr_type = i[0];
            tick();
            if (i == 11) chk("sat.drop_mid", 32'(drop_count), 10);
        end
        ncap_intr = 0;
        chk("sat.drop", 32'(drop_count), 15);
        chk("sat.pend", 32'(pend_valid), 1);
        chk("sat.req", 32'(msi_req), 1);
        chk("sat.sent", 32'(sent_count), 0);
        rst = 1;
        tick();
        rst = 0;
        chk("sat.rst.req", 32'(msi_req), 0);
        chk("sat.rst.busy", 32'(busy), 0);
        chk("sat.rst.pend", 32'(pend_valid), 0);
        chk("sat.rst.drop", 32'(drop_count), 0);
        tick();
        chk("sat.rst.idle_stays", 32'(msi_req), 0);

        // Ack timeout: first grant, then no ack.
        do_reset();
        ack_timeout = 8;
        ncap_intr = 1; ncap_intr_type = 1;
        tick();
        ncap_intr = 0;
        msi_grant = 1;
        tick();
        msi_grant = 0;
        chk("to.sent1", 32'(sent_count), 1);
`ifdef NCAP_INTR_TIMEOUT_EN
        // WAIT_ACK lasts ack_timeout cycles; request is low for those 8 cycles.
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("to.req_low_m%0d", k), 32'(msi_req), 0);
            tick();
        end
        chk("to.req_retry", 32'(msi_req), 1);
        chk("to.vec_retry", 32'(msi_vector), 1);
        msi_grant = 1;
        tick();
        msi_grant = 0;
        chk("to.sent2", 32'(sent_count), 2);
`else
        saw_req = 0;
        for (int k = 0; k < 1000; k++) begin
            if (msi_req) saw_req = 1;
            tick();
        end
        chk("to.no_retry", 32'(saw_req), 0);
        chk("to.still_busy", 32'(busy), 1);
        chk("to.sent_hold", 32'(sent_count), 1);
`endif
        ack_timeout = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ncap_intr_ctrl.md
# ncap_intr_ctrl

Interrupt delivery block for the NCAP power-management path. Takes the single-cycle interrupt/type pair from the traffic monitor and turns it into an MSI request toward the PCIe core. It then holds the event until the driver acknowledges it through a register write, and enforces a minimum holdoff between deliveries. One event of backlog is buffered; further events coalesce into it and are counted as drops.

## Interface
- `CNT_W`, 16: width of the statistics counters.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ncap_intr` in 1: event pulse from the monitor; every cycle it is high counts as one event.
- `ncap_intr_type` in 1: type qualifying `ncap_intr`; 1 = go high-performance, 0 = go low-power.
- `holdoff` in 32: idle cycles enforced after each driver ack; sampled on entry to HOLDOFF.
- `ack_timeout` in 32: cycles to wait in WAIT_ACK before retry; 0 disables. Only used with the macro.
- `msi_req` out 1: MSI request to the PCIe core.
- `msi_vector` out 1: vector offset for the request, equal to the type being delivered.
- `msi_grant` in 1: PCIe core accepts the request.
- `drv_ack` in 1: single-cycle pulse from the driver's register write acknowledging the interrupt.
- `busy` out 1: high when state ≠ IDLE.
- `cur_type` out 1: type of the interrupt currently in flight or last delivered.
- `pend_valid` out 1: the backlog slot holds an event.
- `sent_count` out CNT_W: number of granted MSIs; wraps.
- `drop_count` out CNT_W: number of coalesced events; saturates at all-ones.

## Operation
- **States:** IDLE, REQ, WAIT_ACK, HOLDOFF. One-hot, 4 bits.
- **IDLE**
  - If `pend_valid`: move the slot into `cur_type`, clear the slot, go to REQ.
  - Else if `ncap_intr`: load `ncap_intr_type` into `cur_type`, go to REQ.
- **REQ**
  - Hold `msi_req` = 1 and `msi_vector` = `cur_type` until `msi_grant` is sampled high.
  - On grant, increment `sent_count` and go to WAIT_ACK.
- **WAIT_ACK**
  - On `drv_ack`, load the holdoff counter with `holdoff` and go to HOLDOFF.
  - If `holdoff` = 0, go straight to IDLE instead.
- **HOLDOFF:** decrement the counter each cycle; go to IDLE in the cycle the counter reads 1.
- **Events while not IDLE:**
  - If the slot is empty: fill it with the event's type and set `pend_valid`.
  - If the slot is full: overwrite the type (newest wins) and increment `drop_count`.
- **Events in IDLE:**
  - Slot valid and `ncap_intr` in the same cycle: the slot is dequeued and the new event refills it. `drop_count` does not increment.
  - Slot empty: the event issues directly and is not stored in the slot.
- **Ignored inputs:**
  - `drv_ack` outside WAIT_ACK, including one arriving together with `msi_grant`.
  - `msi_grant` outside REQ.

## Timing
- Reset: state IDLE. `msi_req`, `msi_vector`, `busy`, `cur_type`, `pend_valid`, `sent_count`, `drop_count` and the holdoff counter are all 0.
- `ncap_intr` high in cycle N while IDLE → `msi_req` high from cycle N+1.
- Grant sampled in cycle M → `msi_req` low in cycle M+1, `sent_count` updated in M+1.
- `drv_ack` in cycle A, `holdoff` = H > 0 → `busy` high through A+H and low in A+H+1. The next `msi_req` can rise no earlier than A+H+2.
- `drv_ack` in cycle A, `holdoff` = 0 → IDLE in A+1.
- All outputs are registered.
- `rst` asserted in any state returns to IDLE next cycle. An in-flight request and the slot are discarded, not delivered.

## Configuration
- `NCAP_INTR_TIMEOUT_EN` defined:
  - A 32-bit counter runs in WAIT_ACK.
  - If `ack_timeout` ≠ 0 and the counter reaches `ack_timeout` with no `drv_ack`, return to REQ and re-issue the same `cur_type`.
  - The counter clears on every entry to WAIT_ACK.
- Not defined: WAIT_ACK waits indefinitely, the counter logic is absent, and `ack_timeout` is unused.

## Test plan
- Single event: `ncap_intr`=1 with type 1 in cycle 10, grant in cycle 13 → `msi_req` high cycles 11–13, `msi_vector`=1, `sent_count`=1. Then `drv_ack` in cycle 20 with `holdoff`=5 → `busy` falls in cycle 26.
- Coalescing: three events (types 1, 0, 0) during WAIT_ACK → `pend_valid`=1, slot type 0, `drop_count`=2. After ack with `holdoff`=0, second MSI carries vector 0.
- Saturation: with CNT_W=4, 20 coalesced events → `drop_count` holds at 15.
- Spurious handshakes: `drv_ack` in IDLE and `msi_grant` in IDLE/WAIT_ACK → no state change, counters unchanged.
- Reset mid-REQ with the slot full → next cycle IDLE, `msi_req`=0, `pend_valid`=0, all counters 0.
- With `NCAP_INTR_TIMEOUT_EN`, `ack_timeout`=8 and no ack → `msi_req` re-asserts 8 cycles after the first grant, and `sent_count`=2 after the second grant. Without the macro, no retry within 1000 cycles.
